// File: rtl/pulse_burst_ctrl.sv
// Runtime-programmable pulse burst sequencer: validated (D, P, N) commands drive one registered strobe.
// Optional one-deep pending command slot for zero-gap chaining: define PULSE_BURST_PRELOAD_EN.
module pulse_burst_ctrl #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CNT_W-1:0]   cmd_duration,
    input  logic [CNT_W-1:0]   cmd_period,
    input  logic [BURST_W-1:0] cmd_count,
    input  logic               abort,
    output logic               pulse,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [BURST_W-1:0] pulses_left
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]   dur_q, dur_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [BURST_W-1:0] num_q, num_d;
    logic [BURST_W-1:0] left_q, left_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               cmd_ok;
    logic               period_end;
    logic               more_pulses;
    logic               load_en;
    logic [CNT_W-1:0]   ld_dur;
    logic [CNT_W-1:0]   ld_per;
    logic [BURST_W-1:0] ld_num;

`ifdef PULSE_BURST_PRELOAD_EN
    logic               slot_v_q, slot_v_d;
    logic [CNT_W-1:0]   slot_dur_q, slot_dur_d;
    logic [CNT_W-1:0]   slot_per_q, slot_per_d;
    logic [BURST_W-1:0] slot_num_q, slot_num_d;

    assign cmd_ready = (state_q == ST_IDLE) || !slot_v_q;
`else
    assign cmd_ready = (state_q == ST_IDLE);
`endif

    assign xfer        = cmd_valid && cmd_ready;
    assign cmd_ok      = (cmd_duration != '0) && (cmd_duration < cmd_period);
    // phase_q runs 1..P within each period; pulse is high for phases 1..D
    assign period_end  = (phase_q == per_q);
    assign more_pulses = (num_q == '0) || (left_q > BURST_W'(1));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dur_d   = dur_q;
        per_d   = per_q;
        num_d   = num_q;
        left_d  = left_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        load_en = 1'b0;
        ld_dur  = cmd_duration;
        ld_per  = cmd_period;
        ld_num  = cmd_count;
`ifdef PULSE_BURST_PRELOAD_EN
        slot_v_d   = slot_v_q;
        slot_dur_d = slot_dur_q;
        slot_per_d = slot_per_q;
        slot_num_d = slot_num_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (cmd_ok) begin
                        load_en = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                    left_d  = '0;
`ifdef PULSE_BURST_PRELOAD_EN
                    slot_v_d = 1'b0;
`endif
                end else begin
                    if (period_end) begin
                        if (more_pulses) begin
                            state_d = ST_HIGH;
                            phase_d = CNT_W'(1);
                            pulse_d = 1'b1;
                            if (num_q != '0) begin
                                left_d = left_q - BURST_W'(1);
                            end
                        end else begin
                            state_d = ST_IDLE;
                            phase_d = '0;
                            pulse_d = 1'b0;
                            busy_d  = 1'b0;
                            left_d  = '0;
                            done_d  = 1'b1;
`ifdef PULSE_BURST_PRELOAD_EN
                            if (slot_v_q) begin
                                load_en  = 1'b1;
                                ld_dur   = slot_dur_q;
                                ld_per   = slot_per_q;
                                ld_num   = slot_num_q;
                                slot_v_d = 1'b0;
                            end else if (xfer && cmd_ok) begin
                                load_en = 1'b1;
                            end
`endif
                        end
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                        pulse_d = (phase_q < dur_q);
                        state_d = (phase_q < dur_q) ? ST_HIGH : ST_LOW;
                    end
`ifdef PULSE_BURST_PRELOAD_EN
                    // A good command arriving exactly at completion was already loaded directly
                    if (xfer) begin
                        if (!cmd_ok) begin
                            err_d = 1'b1;
                        end else if (!(period_end && !more_pulses)) begin
                            slot_v_d   = 1'b1;
                            slot_dur_d = cmd_duration;
                            slot_per_d = cmd_period;
                            slot_num_d = cmd_count;
                        end
                    end
`endif
                end
            end
        endcase

        if (load_en) begin
            state_d = ST_HIGH;
            phase_d = CNT_W'(1);
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            dur_d   = ld_dur;
            per_d   = ld_per;
            num_d   = ld_num;
            left_d  = ld_num;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            dur_q   <= '0;
            per_q   <= '0;
            num_q   <= '0;
            left_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PULSE_BURST_PRELOAD_EN
            slot_v_q   <= 1'b0;
            slot_dur_q <= '0;
            slot_per_q <= '0;
            slot_num_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dur_q   <= dur_d;
            per_q   <= per_d;
            num_q   <= num_d;
            left_q  <= left_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PULSE_BURST_PRELOAD_EN
            slot_v_q   <= slot_v_d;
            slot_dur_q <= slot_dur_d;
            slot_per_q <= slot_per_d;
            slot_num_q <= slot_num_d;
`endif
        end
    end

    assign pulse       = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign pulses_left = left_q;

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Scoreboard bench for pulse_burst_ctrl: per-cycle expectations derived from the burst timing formulas.
module tb_pulse_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_duration = '0;
    logic [15:0] cmd_period = '0;
    logic [7:0]  cmd_count = '0;
    logic        abort = 1'b0;
    logic        pulse;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  pulses_left;

    always #5 clk = ~clk;

    pulse_burst_ctrl #(.CNT_W(16), .BURST_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_duration (cmd_duration),
        .cmd_period   (cmd_period),
        .cmd_count    (cmd_count),
        .abort        (abort),
        .pulse        (pulse),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .pulses_left  (pulses_left)
    );

    typedef struct {
        int         cyc;
        logic       pulse;
        logic       busy;
        logic       done;
        logic       err;
        logic       ready;
        logic [7:0] left;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic ready_when(input logic b);
`ifdef PULSE_BURST_PRELOAD_EN
        return 1'b1;
`else
        return !b;
`endif
    endfunction

    task automatic push_exp(input int c, input logic p, input logic b, input logic d,
                            input logic e, input logic r, input logic [7:0] l);
        exp_t x;
        x.cyc = c; x.pulse = p; x.busy = b; x.done = d; x.err = e; x.ready = r; x.left = l;
        exp_q.push_back(x);
        if (c > last_cyc) last_cyc = c;
    endtask

    task automatic push_idle(input int c, input int k);
        for (int i = 0; i < k; i++) push_exp(c + i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    endtask

    // j = 1 is the cycle right after the accepting edge; n = 0 means continuous
    task automatic push_burst(input int e1, input int d, input int p, input int n,
                              input logic first_done, input int jmax);
        for (int j = 1; j <= jmax; j++) begin
            if (n != 0 && j == n * p + 1) begin
                push_exp(e1 + j - 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
            end else begin
                push_exp(e1 + j - 1, ((j - 1) % p) < d, 1'b1, first_done && (j == 1), 1'b0,
                         ready_when(1'b1), (n == 0) ? 8'd0 : 8'(n - (j - 1) / p));
            end
        end
    endtask

    task automatic run_cmd(input int d, input int p, input int n, output int e1);
        do @(negedge clk); while (cyc <= last_cyc);
        cmd_valid    = 1'b1;
        cmd_duration = 16'(d);
        cmd_period   = 16'(p);
        cmd_count    = 8'(n);
        @(posedge clk);
        #1;
        e1 = cyc;
        cmd_valid = 1'b0;
        $display("cmd D=%0d P=%0d N=%0d presented, first response cycle %0d", d, p, n, e1);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc < cyc) begin
                check("stale_expectation", 32'(mon_e.cyc), 32'(cyc));
            end else begin
                check("pulse", pulse, mon_e.pulse);
                check("busy", busy, mon_e.busy);
                check("done", done, mon_e.done);
                check("err", err, mon_e.err);
                check("cmd_ready", cmd_ready, mon_e.ready);
                check("pulses_left", pulses_left, mon_e.left);
            end
        end
    end

    int rej_d[3] = '{8, 9, 0};
    int rej_p[3] = '{8, 8, 5};

    initial begin
        int e1;

        repeat (3) @(posedge clk);
        #1;
        push_idle(cyc, 3);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            run_cmd(rej_d[i], rej_p[i], 1, e1);
            push_exp(e1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
            push_idle(e1 + 1, 1);
        end

        // continuous, aborted in the first high cycle of the third pulse
        run_cmd(2, 5, 0, e1);
        push_burst(e1, 2, 5, 0, 1'b0, 11);
        push_idle(e1 + 11, 4);
        while (cyc != e1 + 10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("abort issued at cycle %0d", e1 + 10);

        // back-to-back with cmd_valid held across both commands
        do @(negedge clk); while (cyc <= last_cyc);
        cmd_valid = 1'b1; cmd_duration = 16'd1; cmd_period = 16'd2; cmd_count = 8'd1;
        @(posedge clk);
        #1;
        e1 = cyc;
        cmd_duration = 16'd2; cmd_period = 16'd4; cmd_count = 8'd1;
`ifdef PULSE_BURST_PRELOAD_EN
        push_exp(e1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        push_exp(e1 + 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        push_burst(e1 + 2, 2, 4, 1, 1'b1, 5);
        while (cyc < e1 + 1) begin @(posedge clk); #1; end
`else
        push_burst(e1, 1, 2, 1, 1'b0, 3);
        push_burst(e1 + 3, 2, 4, 1, 1'b0, 5);
        while (cyc < e1 + 3) begin @(posedge clk); #1; end
`endif
        cmd_valid = 1'b0;
        $display("back-to-back pair D=1,P=2,N=1 / D=2,P=4,N=1 from cycle %0d", e1);

        // reset pulsed in the low phase of the first period
        run_cmd(4, 10, 3, e1);
        push_burst(e1, 4, 10, 3, 1'b0, 7);
        push_idle(e1 + 7, 3);
        while (cyc != e1 + 6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        $display("mid-burst reset at cycle %0d", e1 + 6);

        run_cmd(3, 8, 4, e1);
        push_burst(e1, 3, 8, 4, 1'b0, 33);
        push_idle(e1 + 33, 2);

        run_cmd(1, 2, 255, e1);
        push_burst(e1, 1, 2, 255, 1'b0, 511);
        push_idle(e1 + 511, 1);

        run_cmd(16'hFFFE, 16'hFFFF, 1, e1);
        push_burst(e1, 16'hFFFE, 16'hFFFF, 1, 1'b0, 65536);
        push_idle(e1 + 65536, 1);

        do @(negedge clk); while (cyc <= last_cyc);
        @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
